// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and constants for the display frame scheduler
package display_pkg;

   localparam int NUM_SRC = 3;
   localparam int BCD_W   = 16;
   localparam logic [1:0] SRC_NONE = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT_START,
      WAIT_DONE,
      GAP
   } state_e;

   // Next source index in round-robin order, wrapping 2 -> 0.
   function automatic logic [1:0] src_next(input logic [1:0] s);
      return (s >= 2'd2) ? 2'd0 : s + 2'd1;
   endfunction

   // Saturating increment so counters stick at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// rtl/display_scheduler_if.sv - request and serializer bus between sources, scheduler and serializer
interface display_scheduler_if;
   import display_pkg::*;

   logic [NUM_SRC-1:0]       req_valid;
   logic [NUM_SRC*BCD_W-1:0] req_bcd;
   logic [NUM_SRC-1:0]       req_ready;
   logic                     ser_busy;
   logic                     ser_load;
   logic [BCD_W-1:0]         ser_bcd;

   // Sources and serializer side.
   modport master (
      output req_valid, req_bcd, ser_busy,
      input  req_ready, ser_load, ser_bcd
   );

   // Scheduler side.
   modport slave (
      input  req_valid, req_bcd, ser_busy,
      output req_ready, ser_load, ser_bcd
   );

endinterface

// File: rtl/display_scheduler_rr_arbiter.sv
// rtl/display_scheduler_rr_arbiter.sv - round-robin pick among requesting sources after the last grant
module rr_arbiter
   import display_pkg::*;
(
   input  logic [NUM_SRC-1:0] req_mask_i,
   input  logic [1:0]         last_grant_i,
   output logic [1:0]         grant_idx_o,
   output logic               grant_valid_o
);

   logic [1:0] cand;

   // Scan all sources starting just after the last grant; no previous grant starts at 0.
   always_comb begin
      grant_idx_o   = 2'd0;
      grant_valid_o = 1'b0;
      cand          = (last_grant_i == SRC_NONE) ? 2'd0 : src_next(last_grant_i);
      for (int k = 0; k < NUM_SRC; k++) begin
         if (!grant_valid_o && req_mask_i[cand]) begin
            grant_idx_o   = cand;
            grant_valid_o = 1'b1;
         end
         cand = src_next(cand);
      end
   end

endmodule

// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - arbitrates BCD frame sources onto one serializer with hold, gap and start timeout
module display_scheduler
   import display_pkg::*;
#(
   parameter int unsigned GAP_CYCLES    = 8,
   parameter int unsigned START_TIMEOUT = 200,
   parameter int unsigned HOLD_FRAMES   = 4
) (
   input  logic                ser_clk,
   input  logic                reset,
   input  logic                enable,
   display_scheduler_if.slave  bus,
   output logic [1:0]          cur_src,
   output logic                frame_done,
   input  logic                err_clear,
   output logic                err_timeout
);

   state_e           state_q, state_d;
   logic [1:0]       cur_src_q, cur_src_d;
   logic [31:0]      hold_q, hold_d;
   logic [31:0]      cnt_q, cnt_d;
   logic [BCD_W-1:0] ser_bcd_q, ser_bcd_d;
   logic             frame_done_q, frame_done_d;
   logic             err_q, err_d;

   logic [1:0]       rr_idx;
   logic             rr_valid;
   logic             keep_cur;
   logic [1:0]       grant_idx;
   logic             ser_load_c;
   logic [NUM_SRC-1:0] req_ready_c;

   rr_arbiter u_rr (
      .req_mask_i    (bus.req_valid),
      .last_grant_i  (cur_src_q),
      .grant_idx_o   (rr_idx),
      .grant_valid_o (rr_valid)
   );

   // The current source keeps the serializer until it has had HOLD_FRAMES frames or stops requesting.
   always_comb begin
      keep_cur  = (cur_src_q != SRC_NONE) && bus.req_valid[cur_src_q] && (hold_q < HOLD_FRAMES);
      grant_idx = keep_cur ? cur_src_q : rr_idx;
   end

   // State register; reset drops any frame in flight without pulses.
   always_ff @(posedge ser_clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cur_src_q    <= SRC_NONE;
         hold_q       <= 32'd0;
         cnt_q        <= 32'd0;
         ser_bcd_q    <= '0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_src_q    <= cur_src_d;
         hold_q       <= hold_d;
         cnt_q        <= cnt_d;
         ser_bcd_q    <= ser_bcd_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
      end
   end

   // Next-state logic; cnt_q counts cycles since ser_load in WAIT_START and gap cycles in GAP.
   always_comb begin
      state_d      = state_q;
      cur_src_d    = cur_src_q;
      hold_d       = hold_q;
      cnt_d        = cnt_q;
      ser_bcd_d    = ser_bcd_q;
      frame_done_d = 1'b0;
      err_d        = err_clear ? 1'b0 : err_q;
      case (state_q)
         IDLE: begin
            if (enable && (keep_cur || rr_valid)) begin
               state_d   = LOAD;
               cur_src_d = grant_idx;
               ser_bcd_d = bus.req_bcd[32'(grant_idx) * BCD_W +: BCD_W];
               hold_d    = (grant_idx == cur_src_q) ? sat_inc(hold_q) : 32'd1;
            end
         end
         LOAD: begin
            state_d = WAIT_START;
            cnt_d   = 32'd1;
         end
         WAIT_START: begin
            if (bus.ser_busy) begin
               state_d = WAIT_DONE;
               cnt_d   = 32'd0;
            end else if (cnt_q + 32'd1 >= START_TIMEOUT) begin
               state_d = GAP;
               err_d   = 1'b1;
               cnt_d   = 32'd0;
            end else begin
               cnt_d   = sat_inc(cnt_q);
            end
         end
         WAIT_DONE: begin
            if (!bus.ser_busy) begin
               state_d      = GAP;
               frame_done_d = 1'b1;
               cnt_d        = 32'd0;
            end
         end
         GAP: begin
            if (cnt_q + 32'd1 >= GAP_CYCLES) begin
               state_d = IDLE;
               cnt_d   = 32'd0;
            end else begin
               cnt_d   = sat_inc(cnt_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Load strobe and accept pulse are both asserted only during the single LOAD cycle.
   always_comb begin
      ser_load_c  = (state_q == LOAD);
      req_ready_c = '0;
      if (state_q == LOAD) begin
         req_ready_c = {{(NUM_SRC-1){1'b0}}, 1'b1} << cur_src_q;
      end
   end

   assign bus.ser_load  = ser_load_c;
   assign bus.req_ready = req_ready_c;
   assign bus.ser_bcd   = ser_bcd_q;
   assign cur_src       = cur_src_q;
   assign frame_done    = frame_done_q;
   assign err_timeout   = err_q;

endmodule

// File: tb/tb_display_scheduler.sv
// tb/tb_display_scheduler.sv - randomized scoreboard bench for display_scheduler
module tb_display_scheduler;
   import display_pkg::*;

   localparam int GAP  = 8;
   localparam int TMO  = 200;
   localparam int HOLD = 4;

   typedef struct packed {
      logic [1:0]  src;
      logic [15:0] word;
   } exp_t;

   logic       ser_clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       err_clear;
   logic [1:0] cur_src;
   logic       frame_done;
   logic       err_timeout;

   display_scheduler_if bus();

   display_scheduler #(
      .GAP_CYCLES    (GAP),
      .START_TIMEOUT (TMO),
      .HOLD_FRAMES   (HOLD)
   ) dut (
      .ser_clk     (ser_clk),
      .reset       (reset),
      .enable      (enable),
      .bus         (bus),
      .cur_src     (cur_src),
      .frame_done  (frame_done),
      .err_clear   (err_clear),
      .err_timeout (err_timeout)
   );

   always #5 ser_clk = ~ser_clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int loads_cnt = 0;
   int last_done = -1;
   bit ser_dead = 1'b0;

   logic [15:0] drv_q [3][$];
   logic [15:0] m_q   [3][$];
   int          m_cur  = 3;
   int          m_hold = 0;
   exp_t        exp_q [$];
   int          grants [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] rand_bcd();
      logic [15:0] r;
      for (int k = 0; k < 4; k++) r[4*k +: 4] = 4'($urandom_range(0, 9));
      return r;
   endfunction

   task automatic push_word(input int s, input logic [15:0] w);
      drv_q[s].push_back(w);
      m_q[s].push_back(w);
   endtask

   // Reference: replay the hold/round-robin rule over the pending word lists.
   task automatic plan();
      int s;
      int c;
      exp_t e;
      while (m_q[0].size() + m_q[1].size() + m_q[2].size() > 0) begin
         s = -1;
         if (m_cur != 3 && m_q[m_cur].size() > 0 && m_hold < HOLD) s = m_cur;
         else begin
            for (int k = 0; k < 3; k++) begin
               c = (m_cur == 3) ? k : (m_cur + 1 + k) % 3;
               if (s < 0 && m_q[c].size() > 0) s = c;
            end
         end
         m_hold = (s == m_cur) ? m_hold + 1 : 1;
         m_cur  = s;
         e.src  = 2'(s);
         e.word = m_q[s].pop_front();
         exp_q.push_back(e);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge ser_clk);
      reset = 1'b0;
      m_cur  = 3;
      m_hold = 0;
   endtask

   task automatic drain(input int settle);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 8000) begin
         @(negedge ser_clk);
         t++;
      end
      check("drain", exp_q.size(), 0);
      repeat (settle) @(negedge ser_clk);
   endtask

   task automatic wait_sig(input string name, input int which, input int limit);
      int t;
      bit hit;
      t = 0;
      hit = 1'b0;
      while (!hit && t < limit) begin
         @(negedge ser_clk);
         t++;
         case (which)
            0: hit = bus.ser_load;
            1: hit = bus.ser_busy;
            2: hit = frame_done;
            default: hit = !bus.ser_busy;
         endcase
      end
      check(name, hit, 1);
   endtask

   always @(posedge ser_clk) cyc <= cyc + 1;

   // Source driver: each source presents the head of its list until accepted.
   initial begin
      bus.req_valid = '0;
      bus.req_bcd   = '0;
      forever begin
         @(negedge ser_clk);
         for (int i = 0; i < 3; i++) begin
            if (bus.req_ready[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
            bus.req_valid[i]       = drv_q[i].size() > 0;
            bus.req_bcd[16*i +: 16] = (drv_q[i].size() > 0) ? drv_q[i][0] : 16'h0;
         end
      end
   end

   // Serializer model: busy 33 cycles after a 2-cycle start delay, or never when dead.
   initial begin
      bus.ser_busy = 1'b0;
      forever begin
         @(negedge ser_clk);
         if (bus.ser_load && !ser_dead) begin
            repeat (2) @(negedge ser_clk);
            bus.ser_busy = 1'b1;
            repeat (33) @(negedge ser_clk);
            bus.ser_busy = 1'b0;
         end
      end
   end

   // Monitor: pop the scoreboard on every load and compare the presented frame.
   initial begin
      exp_t e;
      logic [2:0] rdy;
      forever begin
         @(negedge ser_clk);
         if (frame_done) begin
            done_cnt++;
            last_done = cyc;
         end
         if (bus.ser_load) begin
            loads_cnt++;
            grants.push_back(int'(cur_src));
            check("load_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e   = exp_q.pop_front();
               rdy = 3'b001 << e.src;
               check("ser_bcd", bus.ser_bcd, e.word);
               check("cur_src", cur_src, e.src);
               check("req_ready", bus.req_ready, rdy);
            end
            if (last_done >= 0) check("gap_spacing", (cyc - last_done) >= GAP + 1, 1);
         end else begin
            check("ready_idle", bus.req_ready, 0);
         end
      end
   end

   initial begin
      #2000000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      int d0;
      int l0;
      int n;
      int seq [13];
      seq = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0};
      reset     = 1'b1;
      enable    = 1'b1;
      err_clear = 1'b0;
      do_reset();

      check("rst_ser_load", bus.ser_load, 0);
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_ser_bcd", bus.ser_bcd, 0);
      check("rst_cur_src", cur_src, 3);
      check("rst_err", err_timeout, 0);

      // Single source 1 with load latency.
      @(posedge ser_clk); #1;
      push_word(1, 16'h1234);
      plan();
      @(negedge ser_clk);
      check("latency_pre", bus.ser_load, 0);
      @(negedge ser_clk);
      check("latency_load", bus.ser_load, 1);
      drain(60);

      // All three sources continuously valid from reset.
      do_reset();
      grants.delete();
      d0 = done_cnt; l0 = loads_cnt;
      @(posedge ser_clk); #1;
      for (int i = 0; i < 3; i++) for (int j = 0; j < 5; j++) push_word(i, rand_bcd());
      plan();
      drain(60);
      check("grant_count", grants.size() >= 13, 1);
      for (int i = 0; i < 13 && i < grants.size(); i++)
         check($sformatf("grant_seq_%0d", i), grants[i], seq[i]);
      check("done_per_load_all", done_cnt - d0, loads_cnt - l0);

      // Random request mixes.
      for (int r = 0; r < 4; r++) begin
         d0 = done_cnt; l0 = loads_cnt;
         @(posedge ser_clk); #1;
         for (int i = 0; i < 3; i++) begin
            n = $urandom_range(0, 4);
            for (int j = 0; j < n; j++) push_word(i, rand_bcd());
         end
         plan();
         drain(60);
         check("done_per_load_rand", done_cnt - d0, loads_cnt - l0);
      end

      // Start timeout with a dead serializer.
      ser_dead = 1'b1;
      d0 = done_cnt;
      @(posedge ser_clk); #1;
      push_word(0, 16'h0505);
      plan();
      wait_sig("tmo_load1", 0, 20);
      n = 0;
      do begin
         @(negedge ser_clk);
         n++;
      end while (!err_timeout && n < 400);
      check("tmo_latency", n, TMO);
      repeat (20) @(negedge ser_clk);
      check("tmo_sticky", err_timeout, 1);
      err_clear = 1'b1;
      @(negedge ser_clk);
      err_clear = 1'b0;
      check("tmo_cleared", err_timeout, 0);
      @(posedge ser_clk); #1;
      push_word(2, 16'h0909);
      plan();
      wait_sig("tmo_load2", 0, 20);
      repeat (TMO - 1) @(negedge ser_clk);
      check("tmo_not_early", err_timeout, 0);
      err_clear = 1'b1;
      @(negedge ser_clk);
      err_clear = 1'b0;
      check("tmo_set_wins", err_timeout, 1);
      repeat (GAP + 5) @(negedge ser_clk);
      check("tmo_no_done", done_cnt - d0, 0);
      ser_dead  = 1'b0;
      err_clear = 1'b1;
      @(negedge ser_clk);
      err_clear = 1'b0;

      // Reset during WAIT_DONE.
      @(posedge ser_clk); #1;
      push_word(0, 16'h9876);
      plan();
      wait_sig("rst_mid_busy", 1, 20);
      repeat (3) @(negedge ser_clk);
      d0 = done_cnt;
      reset = 1'b1;
      @(negedge ser_clk);
      check("rst_mid_cur_src", cur_src, 3);
      check("rst_mid_ser_bcd", bus.ser_bcd, 0);
      check("rst_mid_frame_done", frame_done, 0);
      check("rst_mid_ser_load", bus.ser_load, 0);
      check("rst_mid_req_ready", bus.req_ready, 0);
      reset  = 1'b0;
      m_cur  = 3;
      m_hold = 0;
      wait_sig("rst_mid_busy_end", 3, 60);
      repeat (20) @(negedge ser_clk);
      check("rst_mid_no_done", done_cnt - d0, 0);

      // Enable dropped while a frame is in flight.
      d0 = done_cnt;
      @(posedge ser_clk); #1;
      push_word(1, 16'h0421);
      push_word(2, 16'h0777);
      plan();
      wait_sig("en_busy", 1, 20);
      @(negedge ser_clk);
      enable = 1'b0;
      wait_sig("en_frame_done", 2, 100);
      l0 = loads_cnt;
      repeat (80) @(negedge ser_clk);
      check("en_blocked", loads_cnt - l0, 0);
      enable = 1'b1;
      n = 0;
      while (loads_cnt == l0 && n < 20) begin
         @(negedge ser_clk);
         n++;
      end
      check("en_resumed", loads_cnt - l0, 1);
      drain(60);
      check("en_done_count", done_cnt - d0, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 Parameter: GAP_CYCLES, default 8, idle ser_clk cycles enforced between frames.
REQ-002 Parameter: START_TIMEOUT, default 200, ser_clk cycles allowed from ser_load to ser_busy rising.
REQ-003 Parameter: HOLD_FRAMES, default 4, minimum consecutive frames granted to one source while it stays valid.
REQ-004 ser_clk  in  1  clock for all logic, rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 enable  in  1  permits new arbitration when high.
REQ-007 req_valid  in  3  per-source request; source holds it and its data until accepted.
REQ-008 req_bcd  in  48  three 16-bit BCD words; source i on bits [16i+15:16i].
REQ-009 req_ready  out  3  one-hot one-cycle accept pulse.
REQ-010 ser_busy  in  1  serializer transmitting indication.
REQ-011 ser_load  out  1  one-cycle pulse: serializer latches ser_bcd.
REQ-012 ser_bcd  out  16  registered frame word presented to serializer.
REQ-013 cur_src  out  2  index of the last granted source, 3 = none.
REQ-014 frame_done  out  1  one-cycle pulse when the serializer finishes a frame.
REQ-015 err_clear  in  1  clears err_timeout.
REQ-016 err_timeout  out  1  sticky: the serializer never started a loaded frame.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, WAIT_START, WAIT_DONE and GAP.
REQ-018 IDLE: when enable=1 and any req_valid=1, the block SHALL grant one source, capture its req_bcd into ser_bcd, update cur_src, and go to LOAD on the next edge.
REQ-019 Grant rule: if cur_src is valid and its hold count < HOLD_FRAMES, keep cur_src; otherwise grant round-robin starting at cur_src+1 mod 3, with cur_src=3 starting at 0.
REQ-020 Hold count SHALL reset to 1 on a source change and increment, saturating, on a repeat grant.
REQ-021 LOAD: ser_load=1 and req_ready[cur_src]=1 for exactly this one cycle, then WAIT_START.
REQ-022 WAIT_START: on ser_busy=1 go to WAIT_DONE; if START_TIMEOUT cycles elapse first, set err_timeout and go to GAP with no frame_done.
REQ-023 WAIT_DONE: on ser_busy=0 pulse frame_done for one cycle and go to GAP.
REQ-024 GAP: count GAP_CYCLES cycles, then go to IDLE; GAP_CYCLES=0 returns to IDLE after 1 cycle.
REQ-025 enable=0 SHALL block only the IDLE grant; a frame already in progress completes.
REQ-026 ser_bcd SHALL hold its value from capture until the next grant.
REQ-027 If err_clear and a new timeout occur in the same cycle, err_timeout SHALL be 1 (set wins).
REQ-028 Latency: req_valid high in IDLE leads to ser_load one cycle later.
REQ-029 Counters SHALL be 32-bit and SHALL never wrap.

Reset
REQ-030 On reset: state=IDLE; ser_load=0, req_ready=0, frame_done=0, ser_bcd=0, cur_src=3, hold count=0, err_timeout=0, all counters=0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame immediately, with no frame_done or req_ready pulse.

Structure
REQ-032 The package display_pkg SHALL hold the FSM state enum, NUM_SRC=3, BCD_W=16 and the SRC_NONE=3 constant.
REQ-033 Round-robin selection SHALL be the sub-module rr_arbiter: inputs request mask and last grant; output grant index plus grant-valid flag.

Verification
REQ-034 Single source 1: req_valid=3'b010, req_bcd[31:16]=16'h1234 -> ser_load one cycle later, ser_bcd=16'h1234, req_ready=3'b010, cur_src=1.
REQ-035 All three sources valid continuously, HOLD_FRAMES=4 -> grant sequence 0,0,0,0,1,1,1,1,2,2,2,2,0...
REQ-036 Serializer model busy 33 cycles after 2-cycle delay -> frame_done exactly once per frame; next ser_load no earlier than GAP_CYCLES+1 cycles after frame_done.
REQ-037 ser_busy tied 0 -> err_timeout rises 200 cycles after ser_load and stays high; err_clear pulsed -> 0; err_clear coincident with a new timeout -> stays 1.
REQ-038 Reset asserted in WAIT_DONE -> next cycle state=IDLE, cur_src=3, ser_bcd=0, no frame_done pulse.
REQ-039 enable dropped during WAIT_DONE -> frame completes with frame_done; no further ser_load until enable=1.
